buffer_port: RTL and testbench

- Initiator-side adapter for the edge-triggered FIFO buffer protocol: we/re strobes, w_ack/r_ack handshakes, full/avail status.
- Converts an upstream valid/ready push stream into buffer writes.
- Converts buffer reads into a downstream valid/ready pop stream with a one-word output register.
- Sits between pipeline stages and each inter-stage buffer.
- Owns the strobe timing and ack-timeout checking, so the buffer never sees a write while full or a read while empty.

---
 rtl/buffer_pkg.sv | 19 +
 rtl/buf_strobe_ctl.sv | 69 ++++++
 rtl/buffer_port.sv | 104 ++++++++++
 tb/tb_buffer_port.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/buffer_pkg.sv
// Shared definitions for the FIFO buffer initiator port.
//   strobe_state_e : encoding of the 3-state strobe/handshake FSM
//   DATA_L_DEFAULT : default data word width
//   to_cnt_w()     : width of a counter able to hold 0..ack_timeout
package buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2
  } strobe_state_e;

  localparam int DATA_L_DEFAULT = 16;

  function automatic int to_cnt_w(input int ack_timeout);
    return $clog2(ack_timeout + 1);
  endfunction

endpackage

// File: rtl/buf_strobe_ctl.sv
// One strobe/ack handshake channel (used once for writes, once for reads).
//   start   : request a transfer; honoured only while idle
//   ack     : raw acknowledge from the buffer (registered here before use)
//   strobe  : we/re level to the buffer, high for the whole REQ state
//   idle    : FSM is in IDLE
//   done    : single-cycle pulse, ack seen in REQ (data may be captured)
//   timeout : single-cycle pulse, REQ lasted ACK_TIMEOUT cycles without ack
module buf_strobe_ctl
  import buffer_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic ack,
  output logic strobe,
  output logic idle,
  output logic done,
  output logic timeout
);

  localparam int            CW   = to_cnt_w(ACK_TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(ACK_TIMEOUT - 1);

  strobe_state_e state, state_nxt;
  logic          ack_q;
  logic [CW-1:0] cnt;

  // The counter is held at zero outside REQ, so every REQ entry starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ack_q <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      ack_q <= ack;
      if (state != ST_REQ) cnt <= '0;
      else                 cnt <= cnt + 1'b1;
    end
  end

  // An ack in the final REQ cycle still counts as a success.
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    timeout   = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_REQ;
      ST_REQ: begin
        if (ack_q) begin
          state_nxt = ST_REL;
          done      = 1'b1;
        end else if (cnt == LAST) begin
          state_nxt = ST_IDLE;
          timeout   = 1'b1;
        end
      end
      ST_REL:  if (!ack_q) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Strobe is decoded from the state register, so reset drops it at once.
  assign strobe = (state == ST_REQ);
  assign idle   = (state == ST_IDLE);

endmodule

// File: rtl/buffer_port.sv
// Initiator-side adapter between a valid/ready pipeline and an edge-triggered
// FIFO buffer (we/re strobes, w_ack/r_ack handshakes, full/avail status).
//   push_*  : upstream valid/ready stream, turned into buffer writes
//   pop_*   : downstream valid/ready stream fed from a one-word output register
//   buf_*   : buffer-side strobes, data and status
//   err_*   : sticky ack-timeout flags, cleared by err_clr (a new timeout wins)
// ACK_TIMEOUT must be at least 2.
module buffer_port
  import buffer_pkg::*;
#(
  parameter int DATA_L      = DATA_L_DEFAULT,
  parameter int ACK_TIMEOUT = 15,
  parameter int PORT_ID     = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [DATA_L-1:0] push_data,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [DATA_L-1:0] pop_data,
  output logic              buf_we,
  output logic [DATA_L-1:0] buf_din,
  input  logic              buf_w_ack,
  output logic              buf_re,
  input  logic [DATA_L-1:0] buf_dout,
  input  logic              buf_r_ack,
  input  logic              buf_full,
  input  logic              buf_avail,
  output logic              err_wr_to,
  output logic              err_rd_to,
  input  logic              err_clr
);

  logic full_q, avail_q;
  logic w_idle, w_start, w_timeout, wr_done_unused;
  logic r_idle, r_start, r_done, r_timeout;

  // Writes start only from idle with the registered full clear, reads only
  // with registered avail set and room in the output register. The
  // handshake takes at least four cycles, long enough for the status copies
  // to reflect this port's own previous transfer.
  assign push_ready = w_idle && !full_q;
  assign w_start    = push_valid && push_ready;
  assign r_start    = r_idle && avail_q && (!pop_valid || pop_ready);

  buf_strobe_ctl #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_wr (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (w_start),
    .ack    (buf_w_ack),
    .strobe (buf_we),
    .idle   (w_idle),
    .done   (wr_done_unused),
    .timeout(w_timeout)
  );

  buf_strobe_ctl #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_rd (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (r_start),
    .ack    (buf_r_ack),
    .strobe (buf_re),
    .idle   (r_idle),
    .done   (r_done),
    .timeout(r_timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q    <= 1'b0;
      avail_q   <= 1'b0;
      buf_din   <= '0;
      pop_valid <= 1'b0;
      pop_data  <= '0;
      err_wr_to <= 1'b0;
      err_rd_to <= 1'b0;
    end else begin
      full_q  <= buf_full;
      avail_q <= buf_avail;
      if (w_start) buf_din <= push_data;
      // A capture refills the register even if the old word leaves this cycle.
      if (r_done) begin
        pop_data  <= buf_dout;
        pop_valid <= 1'b1;
      end else if (pop_ready) begin
        pop_valid <= 1'b0;
      end
      if (w_timeout)    err_wr_to <= 1'b1;
      else if (err_clr) err_wr_to <= 1'b0;
      if (r_timeout)    err_rd_to <= 1'b1;
      else if (err_clr) err_rd_to <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n && w_timeout) $display("buffer_port %0d: write ack timeout", PORT_ID);
    if (rst_n && r_timeout) $display("buffer_port %0d: read ack timeout", PORT_ID);
  end
`endif

endmodule

// File: tb/tb_buffer_port.sv
// Directed + randomized bench for buffer_port. Buffer-side inputs come either
// from directed values (optionally echoing the strobes as acks) or from a
// behavioural 8-entry FIFO buffer. Popped words are checked against a queue
// of the words the bench pushed.
module tb_buffer_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        push_valid = 1'b0, pop_ready = 1'b0, err_clr = 1'b0;
  logic [15:0] push_data = '0;
  logic        push_ready, pop_valid, buf_we, buf_re, err_wr_to, err_rd_to;
  logic [15:0] pop_data, buf_din;
  logic        buf_w_ack, buf_r_ack, buf_full, buf_avail;
  logic [15:0] buf_dout;

  // directed-mode controls
  logic        model = 1'b0, echo_w = 1'b0, echo_r = 1'b0;
  logic        t_full = 1'b0, t_avail = 1'b0;
  logic [15:0] t_dout = '0;

  // behavioural buffer (depth 8)
  logic        m_w_ack, m_r_ack;
  logic [15:0] m_dout;
  logic [15:0] mem [8];
  int          m_cnt, m_wp, m_rp, m_d, wr_err, rd_err;

  int tests = 0, fails = 0;
  logic [15:0] push_q[$], pop_q[$];
  logic [15:0] words [24];

  assign buf_w_ack = model ? m_w_ack : (echo_w & buf_we);
  assign buf_r_ack = model ? m_r_ack : (echo_r & buf_re);
  assign buf_full  = model ? (m_cnt == 8) : t_full;
  assign buf_avail = model ? (m_cnt != 0) : t_avail;
  assign buf_dout  = model ? m_dout : t_dout;

  buffer_port #(.DATA_L(16), .ACK_TIMEOUT(15), .PORT_ID(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
    .buf_we(buf_we), .buf_din(buf_din), .buf_w_ack(buf_w_ack),
    .buf_re(buf_re), .buf_dout(buf_dout), .buf_r_ack(buf_r_ack),
    .buf_full(buf_full), .buf_avail(buf_avail),
    .err_wr_to(err_wr_to), .err_rd_to(err_rd_to), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Edge-triggered buffer: acts on a strobe while its ack is low, acks,
  // and drops the ack once the strobe is released.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_w_ack <= 1'b0; m_r_ack <= 1'b0; m_dout <= '0;
      m_cnt <= 0; m_wp <= 0; m_rp <= 0; wr_err <= 0; rd_err <= 0;
    end else if (model) begin
      m_d = 0;
      if (buf_we && !m_w_ack) begin
        m_w_ack <= 1'b1;
        if (m_cnt == 8) wr_err <= wr_err + 1;
        else begin mem[m_wp] <= buf_din; m_wp <= (m_wp + 1) % 8; m_d = m_d + 1; end
      end else if (!buf_we) m_w_ack <= 1'b0;
      if (buf_re && !m_r_ack) begin
        m_r_ack <= 1'b1;
        if (m_cnt == 0) rd_err <= rd_err + 1;
        else begin m_dout <= mem[m_rp]; m_rp <= (m_rp + 1) % 8; m_d = m_d - 1; end
      end else if (!buf_re) m_r_ack <= 1'b0;
      m_cnt <= m_cnt + m_d;
    end
  end

  // stream monitor
  always @(posedge clk) begin
    if (rst_n) begin
      if (push_valid && push_ready) push_q.push_back(push_data);
      if (pop_valid && pop_ready)   pop_q.push_back(pop_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m, sent, budget;
    logic prev, seen, acc;

    // ---------------- reset state
    #2;
    check("rst_we", buf_we, 0);
    check("rst_re", buf_re, 0);
    check("rst_pop_valid", pop_valid, 0);
    check("rst_din", buf_din, 0);
    check("rst_pop_data", pop_data, 0);
    check("rst_err", {err_wr_to, err_rd_to}, 0);
    #8 rst_n = 1'b1;
    tick();

    // ---------------- single push, echoed ack
    echo_w = 1'b1;
    push_valid = 1'b1; push_data = 16'hA5A5;
    check("push_ready_idle", push_ready, 1);
    tick();
    push_valid = 1'b0;
    n = 0; m = 0;
    for (int i = 0; i < 6; i++) begin
      if (buf_we) n++;
      if (!push_ready) m++;
      if (i == 0) check("din_latched", buf_din, 16'hA5A5);
      tick();
    end
    check("we_cycles", n, 2);
    check("push_ready_low_cycles", m, 4);
    check("push_ready_back", push_ready, 1);
    check("din_stable", buf_din, 16'hA5A5);

    // ---------------- full stall
    t_full = 1'b1;
    tick();
    push_valid = 1'b1; push_data = 16'h1111;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (buf_we || push_ready) n++;
      tick();
    end
    check("full_stall", n, 0);
    t_full = 1'b0;
    tick();
    check("full_drop_we_1", buf_we, 0);
    check("full_drop_ready_1", push_ready, 1);
    tick();
    check("full_drop_we_2", buf_we, 1);
    check("full_drop_din", buf_din, 16'h1111);
    push_valid = 1'b0;
    repeat (6) tick();

    // ---------------- pop with backpressure
    echo_r = 1'b1; t_avail = 1'b1; t_dout = 16'h1234; pop_ready = 1'b0;
    n = 0; prev = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (buf_re && !prev) n++;
      prev = buf_re;
      tick();
    end
    check("re_pulses_bp", n, 1);
    check("pop_valid_bp", pop_valid, 1);
    check("pop_data_bp", pop_data, 16'h1234);
    check("re_idle_bp", buf_re, 0);
    t_dout = 16'h5678; pop_ready = 1'b1;
    tick();
    check("pop_consume", pop_valid, 0);
    pop_ready = 1'b0;
    n = 0; prev = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (buf_re && !prev) n++;
      prev = buf_re;
      tick();
    end
    check("re_pulses_2", n, 1);
    check("pop_valid_2", pop_valid, 1);
    check("pop_data_2", pop_data, 16'h5678);
    t_avail = 1'b0;
    tick(); tick();
    pop_ready = 1'b1;
    tick();
    pop_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (buf_re) n++;
      tick();
    end
    check("no_read_when_empty", n, 0);
    check("pop_valid_drained", pop_valid, 0);

    // ---------------- write timeout
    echo_w = 1'b0;
    push_valid = 1'b1; push_data = 16'hBEEF;
    tick();
    push_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (buf_we) n++;
      tick();
    end
    check("wr_to_we_cycles", n, 15);
    check("wr_to_flag", err_wr_to, 1);
    check("wr_to_rd_flag", err_rd_to, 0);
    check("wr_to_ready", push_ready, 1);
    repeat (3) tick();
    check("wr_to_sticky", err_wr_to, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("wr_to_cleared", err_wr_to, 0);

    // ---------------- read timeout with err_clr held throughout
    echo_r = 1'b0; t_avail = 1'b1;
    tick();
    t_avail = 1'b0; err_clr = 1'b1;
    n = 0; prev = 1'b0; seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (buf_re) n++;
      if (prev && !buf_re) seen = err_rd_to;
      prev = buf_re;
      tick();
    end
    err_clr = 1'b0;
    check("rd_to_re_cycles", n, 15);
    check("rd_to_beats_clr", seen, 1);
    check("rd_to_cleared", err_rd_to, 0);
    check("rd_to_no_capture", pop_valid, 0);

    // ---------------- reset mid-request
    t_avail = 1'b1;
    push_valid = 1'b1; push_data = 16'h7777;
    tick();
    push_valid = 1'b0;
    tick();
    check("pre_rst_we", buf_we, 1);
    check("pre_rst_re", buf_re, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_we", buf_we, 0);
    check("async_rst_re", buf_re, 0);
    check("async_rst_pop_valid", pop_valid, 0);
    check("async_rst_din", buf_din, 0);
    t_avail = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick(); tick();
    check("post_rst_ready", push_ready, 1);
    check("post_rst_strobes", {buf_we, buf_re}, 0);
    check("post_rst_err", {err_wr_to, err_rd_to}, 0);

    // ---------------- end-to-end against the behavioural buffer
    model = 1'b1;
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    push_q.delete(); pop_q.delete();
    sent = 0; budget = 0;
    while (sent < 12 && budget < 2000) begin
      push_valid = 1'b1; push_data = 16'(sent + 1);
      pop_ready = 1'($urandom_range(0, 1));
      acc = push_ready;
      tick();
      if (acc) sent++;
      budget++;
    end
    push_valid = 1'b0;
    while (pop_q.size() < 12 && budget < 4000) begin
      pop_ready = 1'($urandom_range(0, 1));
      tick();
      budget++;
    end
    pop_ready = 1'b0;
    check("e2e_sent", sent, 12);
    check("e2e_pop_count", pop_q.size(), 12);
    for (int i = 0; i < pop_q.size(); i++) check("e2e_order", pop_q[i], 32'(i + 1));

    // random data and random valid/ready on both sides
    repeat (6) tick();
    push_q.delete(); pop_q.delete();
    for (int i = 0; i < 24; i++) words[i] = 16'($urandom);
    sent = 0; budget = 0;
    while (sent < 24 && budget < 4000) begin
      push_valid = ($urandom_range(0, 3) != 0);
      push_data = words[sent];
      pop_ready = 1'($urandom_range(0, 1));
      acc = push_valid && push_ready;
      tick();
      if (acc) sent++;
      budget++;
    end
    push_valid = 1'b0;
    while (pop_q.size() < 24 && budget < 8000) begin
      pop_ready = 1'($urandom_range(0, 1));
      tick();
      budget++;
    end
    pop_ready = 1'b0;
    check("rnd_sent", sent, 24);
    check("rnd_pop_count", pop_q.size(), 24);
    n = 0;
    for (int i = 0; i < pop_q.size() && i < 24; i++) if (pop_q[i] !== words[i]) n++;
    check("rnd_order_mismatches", n, 0);
    check("buf_write_while_full", wr_err, 0);
    check("buf_read_while_empty", rd_err, 0);
    check("e2e_err_flags", {err_wr_to, err_rd_to}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
